// File: rtl/nx_xrfb_multiport.sv
// Parametrised multi-read-port register file with per-lane write enables,
// optional registered read stage and a post-reset clear sequencer.
module nx_xrfb_multiport #(
  parameter int              WIDTH          = 18,
  parameter int              DEPTH          = 64,
  parameter int              ADDR_W         = $clog2(DEPTH),
  parameter int              NRD            = 2,
  parameter int              LANE_W         = 9,
  parameter int              RD_REG         = 1,
  parameter int              WRITE_FIRST    = 1,
  parameter int              CLEAR_ON_RESET = 1,
  parameter logic [WIDTH-1:0] CLEAR_VALUE   = '0
) (
  input  logic                    CK,
  input  logic                    R,
  input  logic [ADDR_W-1:0]       WA,
  input  logic [WIDTH-1:0]        I,
  input  logic                    WE,
  input  logic [WIDTH/LANE_W-1:0] WEA,
  input  logic [NRD*ADDR_W-1:0]   RA,
  input  logic [NRD-1:0]          RE,
  output logic [NRD*WIDTH-1:0]    O,
  output logic                    BUSY
);

  localparam int                NLANE   = WIDTH / LANE_W;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  wr_old, wr_word;
  logic              wr_en;

  // Clear sequencer
  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  assign BUSY = (state_q == CLEAR);

  // Write path: lanes without an enable keep the stored value.
  assign wr_en  = WE && !BUSY && ({1'b0, WA} < DEPTH_C) && (|WEA);
  assign wr_old = mem[WA];

  for (genvar k = 0; k < NLANE; k++) begin : g_lane
    assign wr_word[k*LANE_W +: LANE_W] = WEA[k] ? I[k*LANE_W +: LANE_W]
                                                : wr_old[k*LANE_W +: LANE_W];
  end

  always_ff @(posedge CK) begin
    if (BUSY)       mem[cnt_q] <= CLEAR_VALUE;
    else if (wr_en) mem[WA]    <= wr_word;
  end

  // Read ports
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [WIDTH-1:0]  rd_word;

    assign ra      = RA[p*ADDR_W +: ADDR_W];
    assign rd_word = ({1'b0, ra} < DEPTH_C) ? mem[ra] : '0;

    if (RD_REG != 0) begin : g_reg
      logic [WIDTH-1:0] o_q;
      // Same-address write on this edge: bypass the merged word when write-first.
      always_ff @(posedge CK or posedge R) begin
        if (R)                    o_q <= '0;
        else if (RE[p] && !BUSY)  o_q <= ((WRITE_FIRST != 0) && wr_en && (ra == WA))
                                         ? wr_word : rd_word;
      end
      assign O[p*WIDTH +: WIDTH] = o_q;
    end else begin : g_async
      assign O[p*WIDTH +: WIDTH] = rd_word;
    end
  end

  if (RD_REG == 0) begin : g_no_re
    logic unused_re;
    assign unused_re = ^RE;
  end

endmodule

// File: tb/tb_nx_xrfb_multiport.sv
// Randomised bench for nx_xrfb_multiport: three configurations share one
// stimulus stream and are checked against an edge-level behavioural model.
module tb_nx_xrfb_multiport;

  localparam int AW = 6;
  localparam int W  = 18;
  localparam int NP = 4;

  logic              CK = 1'b0;
  logic              R;
  logic [AW-1:0]     WA;
  logic [W-1:0]      I;
  logic              WE;
  logic [1:0]        WEA;
  logic [NP*AW-1:0]  RA;
  logic [NP-1:0]     RE;
  logic [NP*W-1:0]   O_A, O_B, O_C;
  logic              BUSY_A, BUSY_B, BUSY_C;

  always #5 CK = ~CK;

  // A: 64 deep, write-first; B: 48 deep, read-first; C: 48 deep, async read.
  nx_xrfb_multiport #(.WIDTH(W), .DEPTH(64), .NRD(NP), .LANE_W(9), .RD_REG(1),
    .WRITE_FIRST(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(18'h155)) u_a (
    .CK(CK), .R(R), .WA(WA), .I(I), .WE(WE), .WEA(WEA), .RA(RA), .RE(RE),
    .O(O_A), .BUSY(BUSY_A));

  nx_xrfb_multiport #(.WIDTH(W), .DEPTH(48), .NRD(NP), .LANE_W(9), .RD_REG(1),
    .WRITE_FIRST(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(18'h0)) u_b (
    .CK(CK), .R(R), .WA(WA), .I(I), .WE(WE), .WEA(WEA), .RA(RA), .RE(RE),
    .O(O_B), .BUSY(BUSY_B));

  nx_xrfb_multiport #(.WIDTH(W), .DEPTH(48), .NRD(NP), .LANE_W(9), .RD_REG(0),
    .WRITE_FIRST(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(18'h2AAAA)) u_c (
    .CK(CK), .R(R), .WA(WA), .I(I), .WE(WE), .WEA(WEA), .RA(RA), .RE(RE),
    .O(O_C), .BUSY(BUSY_C));

  int         n_chk  = 0;
  int         n_fail = 0;

  int         dep [3] = '{64, 48, 48};
  bit         wf  [3] = '{1'b1, 1'b0, 1'b1};
  bit         rr  [3] = '{1'b1, 1'b1, 1'b0};
  logic [W-1:0] cv [3] = '{18'h155, 18'h0, 18'h2AAAA};

  logic [W-1:0] mm [3][64];
  logic [W-1:0] mo [3][NP];
  int           clr [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] dut_o(input int d, input int p);
    case (d)
      0:       return O_A[p*W +: W];
      1:       return O_B[p*W +: W];
      default: return O_C[p*W +: W];
    endcase
  endfunction

  function automatic logic dut_busy(input int d);
    case (d)
      0:       return BUSY_A;
      1:       return BUSY_B;
      default: return BUSY_C;
    endcase
  endfunction

  function automatic logic [AW-1:0] ra_of(input int p);
    logic [NP*AW-1:0] v;
    v = RA;
    return v[p*AW +: AW];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      clr[d] = dep[d];
      for (int p = 0; p < NP; p++) mo[d][p] = '0;
    end
  endtask

  // One rising edge of the reference behaviour, evaluated from pre-edge inputs.
  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      bit           busy, wok;
      logic [W-1:0] merged;
      busy   = clr[d] > 0;
      wok    = WE && !busy && (int'(WA) < dep[d]) && (WEA != 2'b00);
      merged = mm[d][WA];
      if (WEA[0]) merged[8:0]  = I[8:0];
      if (WEA[1]) merged[17:9] = I[17:9];
      if (rr[d]) begin
        for (int p = 0; p < NP; p++) begin
          if (RE[p] && !busy) begin
            mo[d][p] = (int'(ra_of(p)) < dep[d]) ? mm[d][ra_of(p)] : '0;
            if (wf[d] && wok && ra_of(p) == WA) mo[d][p] = merged;
          end
        end
      end
      if (busy) begin
        mm[d][dep[d] - clr[d]] = cv[d];
        clr[d]--;
      end else if (wok) begin
        mm[d][WA] = merged;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_busy%0d", tag, d), 32'(dut_busy(d)), 32'(clr[d] > 0));
      for (int p = 0; p < NP; p++) begin
        if (rr[d])
          chk($sformatf("%s_o%0d_%0d", tag, d, p), 32'(dut_o(d, p)), 32'(mo[d][p]));
        else if (clr[d] == 0)
          chk($sformatf("%s_o%0d_%0d", tag, d, p), 32'(dut_o(d, p)),
              32'((int'(ra_of(p)) < dep[d]) ? mm[d][ra_of(p)] : '0));
      end
    end
  endtask

  task automatic tick(input string tag);
    if (!R) model_step();
    @(posedge CK);
    #1;
    check_all(tag);
  endtask

  task automatic set_reset(input logic v);
    R = v;
    if (v) begin
      model_reset();
      #1;
      check_all("rst");
    end
  endtask

  task automatic rand_inputs();
    WA  = AW'($urandom_range(0, 63));
    I   = W'($urandom);
    WE  = 1'($urandom_range(0, 1));
    WEA = 2'($urandom_range(0, 3));
    RA  = (NP*AW)'($urandom);
    RE  = NP'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) RA[AW-1:0] = WA;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d, input logic [1:0] en);
    WE = 1'b1; WA = AW'(a); I = d; WEA = en; RE = '0;
    tick("wr");
    WE = 1'b0;
  endtask

  task automatic rd(input int a3, input int a2, input int a1, input int a0);
    WE = 1'b0; RE = '1;
    RA = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    tick("rd");
    RE = '0;
  endtask

  // Writes are held high throughout so every write during the clear must be dropped.
  task automatic wait_clear(input string tag);
    int na = 0, nb = 0, guard = 0;
    while ((BUSY_A || BUSY_B) && guard < 300) begin
      if (BUSY_A) na++;
      if (BUSY_B) nb++;
      rand_inputs();
      WE = 1'b1;
      tick(tag);
      guard++;
    end
    chk({tag, "_len_a"}, 32'(na), 32'd64);
    chk({tag, "_len_b"}, 32'(nb), 32'd48);
  endtask

  initial begin
    WA = '0; I = '0; WE = 1'b0; WEA = '0; RA = '0; RE = '0;
    for (int d = 0; d < 3; d++)
      for (int a = 0; a < 64; a++) mm[d][a] = '0;
    set_reset(1'b1);
    tick("rst_hold");
    tick("rst_hold");
    set_reset(1'b0);
    wait_clear("clr1");

    // Cleared contents, including address 3 that was written during BUSY.
    rd(3, 63, 31, 0);
    chk("clr_a_p0", 32'(O_A[0*W +: W]), 32'h155);
    chk("clr_a_p1", 32'(O_A[1*W +: W]), 32'h155);
    chk("clr_a_p2", 32'(O_A[2*W +: W]), 32'h155);
    chk("clr_a_p3", 32'(O_A[3*W +: W]), 32'h155);

    // Lane write
    wr(5, 18'h3FFFF, 2'b11);
    wr(5, 18'h0, 2'b01);
    rd(0, 0, 0, 5);
    chk("lane_a", 32'(O_A[0 +: W]), 32'h3FE00);
    chk("lane_b", 32'(O_B[0 +: W]), 32'h3FE00);
    chk("lane_c", 32'(O_C[0 +: W]), 32'h3FE00);

    // Collision
    wr(7, 18'h0, 2'b11);
    WE = 1'b1; WA = 7; I = 18'h00ABC; WEA = 2'b11; RE = 4'b0001; RA = {AW'(0), AW'(0), AW'(0), AW'(7)};
    tick("coll");
    WE = 1'b0; RE = '0;
    chk("coll_wf", 32'(O_A[0 +: W]), 32'h00ABC);
    chk("coll_rf", 32'(O_B[0 +: W]), 32'h0);

    // Multiport
    for (int i = 0; i < 4; i++) wr(i, W'(10 + i), 2'b11);
    rd(3, 2, 1, 0);
    for (int p = 0; p < NP; p++)
      chk($sformatf("mport_p%0d", p), 32'(O_A[p*W +: W]), 32'(10 + p));

    // Out of range for the 48-deep instances, in range for A
    wr(50, 18'h01234, 2'b11);
    rd(0, 0, 0, 50);
    chk("oor_a", 32'(O_A[0 +: W]), 32'h01234);
    chk("oor_b", 32'(O_B[0 +: W]), 32'h0);
    chk("oor_c", 32'(O_C[0 +: W]), 32'h0);

    // Async read sees the write right after its edge
    RA = {AW'(0), AW'(0), AW'(0), AW'(9)};
    wr(9, 18'h2A5A5, 2'b11);
    chk("async_c", 32'(O_C[0 +: W]), 32'h2A5A5);

    // Reset mid-clear restarts the sequence
    set_reset(1'b1);
    tick("rst_mid");
    set_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      tick("clr_part");
    end
    set_reset(1'b1);
    tick("rst_mid2");
    tick("rst_mid2");
    set_reset(1'b0);
    wait_clear("clr2");

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rand_inputs();
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nx_xrfb_multiport.md
# nx_xrfb_multiport

Parametrised register-file block for the NanoXplore flow, the successor to the fixed 64x18 / 32x36 XRFB mappings. It generalises the single-write, single-async-read register file in four ways: configurable width and depth, N read ports, per-lane write enables, and an optional registered read stage. A post-reset clear sequencer gives deterministic memory contents. Memory inference targets it when a design needs more than one read port or a clean reset state.

## Interface
- WIDTH, 18: data width in bits; must be a multiple of LANE_W.
- DEPTH, 64: number of words, 2..1024; need not be a power of two.
- ADDR_W, $clog2(DEPTH): address width; derived, not overridden.
- NRD, 2: number of read ports, 1..4.
- LANE_W, 9: bits per write-enable lane. NLANE = WIDTH/LANE_W.
- RD_REG, 1: 1 = registered read, 1-cycle latency; 0 = asynchronous read.
- WRITE_FIRST, 1: registered-read collision policy; 1 = new data, 0 = old data.
- CLEAR_ON_RESET, 1: 1 = clear sequencer enabled.
- CLEAR_VALUE, 0: WIDTH-bit word written by the sequencer.

Ports:
- CK  in  1  clock; all state changes on the rising edge.
- R  in  1  reset, asynchronous, active-high.
- WA  in  ADDR_W  write address.
- I  in  WIDTH  write data.
- WE  in  1  write strobe.
- WEA  in  NLANE  lane enables; lane k covers I[k*LANE_W +: LANE_W].
- RA  in  NRD*ADDR_W  read addresses; port p uses RA[p*ADDR_W +: ADDR_W].
- RE  in  NRD  read enables; used only when RD_REG=1.
- O  out  NRD*WIDTH  read data; port p drives O[p*WIDTH +: WIDTH].
- BUSY  out  1  clear sequence in progress.

## Operation
- Write: on a rising edge with WE=1, BUSY=0 and WA<DEPTH, write lane k of mem[WA] where WEA[k]=1. Other lanes keep their values.
- Writes are dropped when WA>=DEPTH, when WEA is all zeros, or when BUSY=1.
- Out-of-range read (RA_p>=DEPTH) returns all zeros on that port.
- RD_REG=0: O_p = mem[RA_p] combinationally. RE is ignored.
- RD_REG=1: on an edge with RE[p]=1 and BUSY=0, O_p loads mem[RA_p]. With RE[p]=0, O_p holds its value.
- Collision (RD_REG=1, read and write to the same address on the same edge): WRITE_FIRST=1 returns the merged new word (written lanes new, other lanes old). WRITE_FIRST=0 returns the pre-write word.
- Read ports are fully independent. Multiple ports may read the same address.
- Clear sequencer FSM, states IDLE and CLEAR:
  - R=1 with CLEAR_ON_RESET=1 forces CLEAR, count=0, BUSY=1.
  - In CLEAR, each edge after R is released writes CLEAR_VALUE to mem[count] and increments count.
  - On the edge that writes mem[DEPTH-1], the FSM goes to IDLE and BUSY goes 0.
  - With CLEAR_ON_RESET=0 the FSM stays in IDLE, BUSY is constant 0, and memory is X until written.
- Reset asserted mid-clear restarts the sequence from count=0.

## Timing
- Reset values: BUSY=CLEAR_ON_RESET. Registered O = 0. Memory is not reset directly.
- Clear takes exactly DEPTH cycles. BUSY is high on the first DEPTH rising edges after R falls and low from edge DEPTH onward.
- The first user write is accepted on the edge where BUSY is already 0 (edge DEPTH+1 after R release, counting from 1).
- Write-to-read latency:
  - RD_REG=0: data visible on O in the cycle after the write edge.
  - RD_REG=1, different edges: the read edge must come strictly after the write edge, and O updates on the read edge.
- Read latency with RD_REG=1: 1 edge from RA/RE to O.
- While BUSY=1 in registered mode, O holds 0 (RE is ignored).

## Test plan
- Reset clear, DEPTH=64, CLEAR_VALUE=18'h155: release R and count cycles -> BUSY high for exactly 64 edges. Then a read of addresses 0, 31 and 63 returns 18'h155.
- Lane write, WIDTH=18, LANE_W=9: mem[5]=18'h3FFFF, then write I=0 with WEA=2'b01 -> read mem[5]=18'h3FE00.
- Collision, RD_REG=1: mem[7]=0, then on one edge write 18'h00ABC to address 7 with RE[0]=1 and RA0=7. WRITE_FIRST=1 -> O0=18'h00ABC; WRITE_FIRST=0 -> O0=0.
- Multiport, NRD=4: fill addresses 0..3 with 10+i, then read RA={0,1,2,3} in one edge -> O={13,12,11,10} by port 3..0, one cycle later.
- DEPTH=48: write to address 50 -> no memory change, and a read of address 50 returns 0. A write during BUSY is dropped.
- Reset mid-clear: assert R at count=20 for 2 cycles -> BUSY stays high and the clear restarts, completing 64 edges after the second release.
